// File: rtl/ps2_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: register map,
// CSR bit positions, FSM state codes, keyboard command bytes and parity helper.
`timescale 1ns/1ps
package ps2_tx_pkg;

    // Register select, taken from wb_adr_i[1]
    localparam logic REG_TXCSR = 1'b0;
    localparam logic REG_TXBUF = 1'b1;

    // TXCSR bit positions
    localparam int CSR_IE    = 6;
    localparam int CSR_READY = 7;
    localparam int CSR_ERR   = 15;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // Keyboard command bytes
    localparam logic [7:0] PS2_CMD_LED       = 8'hED;
    localparam logic [7:0] PS2_CMD_RST       = 8'hFF;
    localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;

    // PS/2 parity bit: makes the total count of ones over data+parity odd
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for asynchronous PS/2 lines, with a falling-edge
// detector on bit 0 (the clock line). Flops reset to 1, the idle line level,
// so no spurious edge appears when reset is released.
`timescale 1ns/1ps
module ps2_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic         fall
);

    logic [W-1:0] meta;
    logic         last;

    // Synchronize all lines and keep the previous clock-line sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            sync <= '1;
            last <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            last <= sync[0];
        end
    end

    assign fall = last & ~sync[0];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter with a Wishbone slave register interface
// (TXCSR/TXBUF) and a level interrupt towards the vectored interrupt controller.
`timescale 1ns/1ps
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        irq,
    input  logic        iack,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic        tx_busy
);

    localparam int INHIBIT_CYC = CLK_HZ / 1000000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    // One counter serves both the inhibit delay and the frame timeout
    localparam int CNT_W = $clog2(INHIBIT_CYC + TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       nbit;
    logic             data_low;
    logic [7:0]       txbuf;
    logic             ready;
    logic             ie;
    logic             err;
    logic             pend;
    logic [1:0]       line_sync;
    logic             clk_fall;
    logic [15:0]      csr_val;
    logic             req, wr, wr_csr, wr_buf, accept;
    logic             tmo_hit, done_evt;
    logic             unused_bits;

    // Bit 0 carries the clock line so the edge detector watches the clock
    ps2_sync #(.W(2)) u_sync (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .din  ({ps2_data_i, ps2_clk_i}),
        .sync (line_sync),
        .fall (clk_fall)
    );

    assign req    = wb_cyc_i & wb_stb_i;
    // A write acts only on the cycle in which ack rises
    assign wr     = req & ~wb_ack_o & wb_we_i & wb_sel_i[0];
    assign wr_csr = wr & (wb_adr_i[1] == REG_TXCSR);
    assign wr_buf = wr & (wb_adr_i[1] == REG_TXBUF);
    assign accept = wr_buf & ready;

    assign tmo_hit  = (state != ST_IDLE) && (state != ST_INHIBIT) && (cnt == TMO_LAST);
    assign done_evt = tmo_hit | (state == ST_DONE);

    assign ps2_clk_oe  = (state == ST_INHIBIT) | (state == ST_START);
    assign ps2_data_oe = (state == ST_START) | ((state == ST_SHIFT) & data_low);
    assign tx_busy     = (state != ST_IDLE);
    assign irq         = pend & ie & ready;

    assign unused_bits = ^{wb_adr_i[15:2], wb_adr_i[0], wb_dat_i[15:8], wb_sel_i[1]};

    // Assemble the status/control register image
    always_comb begin
        csr_val            = '0;
        csr_val[CSR_ERR]   = err;
        csr_val[CSR_READY] = ready;
        csr_val[CSR_IE]    = ie;
    end

    // Bus acknowledge and registered read data
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            if (req && !wb_ack_o)
                wb_dat_o <= (wb_adr_i[1] == REG_TXBUF) ? {8'h00, txbuf} : csr_val;
        end
    end

    // Frame sequencer: inhibit, start bit, 8 data + parity + stop, device ACK
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            nbit     <= '0;
            data_low <= 1'b0;
            txbuf    <= '0;
            ready    <= 1'b1;
            err      <= 1'b0;
        end else if (tmo_hit) begin
            state    <= ST_IDLE;
            data_low <= 1'b0;
            err      <= 1'b1;
            ready    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        txbuf <= wb_dat_i[7:0];
                        ready <= 1'b0;
                        err   <= 1'b0;
                        cnt   <= '0;
                        state <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt   <= '0;
                        state <= ST_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_START: begin
                    cnt      <= cnt + 1'b1;
                    nbit     <= '0;
                    data_low <= 1'b1;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (clk_fall) begin
                        nbit <= nbit + 1'b1;
                        if (nbit < 4'd8) begin
                            data_low <= ~txbuf[nbit[2:0]];
                        end else if (nbit == 4'd8) begin
                            data_low <= ~odd_parity(txbuf);
                        end else if (nbit == 4'd9) begin
                            data_low <= 1'b0;
                        end else begin
                            // Eleventh falling edge: device pulls data low to ACK
                            if (line_sync[1])
                                err <= 1'b1;
                            state <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt <= cnt + 1'b1;
                    if (line_sync == 2'b11)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Interrupt enable and pending flag; frame completion outranks iack
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ie   <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (wr_csr)
                ie <= wb_dat_i[CSR_IE];
            if (iack || accept || (wr_csr && !wb_dat_i[CSR_IE]))
                pend <= 1'b0;
            if (wr_csr && wb_dat_i[CSR_IE] && !ie && ready)
                pend <= 1'b1;
            if (done_evt)
                pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Testbench for ps2_tx: register table, directed frame scenarios and
// randomized frames against a keyboard device model and a register model.
`timescale 1ns/1ps
module tb_ps2_tx;
    import ps2_tx_pkg::*;

    localparam int CLK_HZ     = 1000000;
    localparam int INHIBIT_US = 100;
    localparam int TIMEOUT_MS = 2;
    localparam int INH = CLK_HZ / 1000000 * INHIBIT_US;
    localparam int TMO = CLK_HZ / 1000 * TIMEOUT_MS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] adr, wdat, rdat;
    logic        cyc, we, stb, ack, irq, iack;
    logic [1:0]  sel;
    logic        clk_oe, data_oe, busy;
    logic        dev_clk_low, dev_data_low;
    logic        ps2_clk, ps2_data;

    int checks = 0;
    int failures = 0;
    int inh_cnt = 0;
    int st_cnt = 0;

    // Register model
    bit         m_ready, m_err, m_ie, m_pend;
    logic [7:0] m_buf;

    assign ps2_clk  = !(clk_oe || dev_clk_low);
    assign ps2_data = !(data_oe || dev_data_low);

    ps2_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_MS(TIMEOUT_MS)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
        .wb_cyc_i(cyc), .wb_we_i(we), .wb_stb_i(stb), .wb_sel_i(sel), .wb_ack_o(ack),
        .irq(irq), .iack(iack), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .tx_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clk_oe && !data_oe) inh_cnt <= inh_cnt + 1;
        if (clk_oe && data_oe)  st_cnt  <= st_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected line bits, index = order on the wire: start, D0..D7, parity, stop
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    function automatic logic [15:0] m_csr();
        return {m_err, 7'b0, m_ready, m_ie, 6'b0};
    endfunction

    function automatic logic m_irq();
        return m_pend & m_ie & m_ready;
    endfunction

    task automatic m_reset();
        m_ready = 1; m_err = 0; m_ie = 0; m_pend = 0; m_buf = 0;
    endtask

    task automatic m_done(input bit ack_ok);
        m_ready = 1; m_err = !ack_ok; m_pend = 1;
    endtask

    task automatic bus(input bit w, input bit a, input logic [15:0] d, input logic [1:0] s,
                       output logic [15:0] q);
        int n;
        cyc = 1; stb = 1; we = w; adr = {14'd0, a, 1'b0}; wdat = d; sel = s;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
        if (!ack) chk("ack_timeout", ack, 1);
        q = rdat;
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        chk("ack_drop", ack, 0);
        if (w && s[0]) begin
            if (!a) begin
                if (!d[6]) m_pend = 0;
                else if (!m_ie && m_ready) m_pend = 1;
                m_ie = d[6];
            end else if (m_ready) begin
                m_buf = d[7:0]; m_ready = 0; m_err = 0; m_pend = 0;
            end
        end
    endtask

    task automatic wr(input bit a, input logic [15:0] d);
        logic [15:0] q;
        bus(1, a, d, 2'b11, q);
    endtask

    task automatic rd(input bit a, output logic [15:0] q);
        bus(0, a, 16'h0, 2'b11, q);
    endtask

    task automatic do_iack();
        iack = 1; @(posedge clk); #1; iack = 0;
        m_pend = 0;
    endtask

    // Keyboard model: clocks the frame in, samples on rising edges, ACKs on clock 11.
    // With nfall < 11 it stops holding the clock low just after that falling edge.
    task automatic device_rx(input int half, input bit ack_ok, input int nfall,
                             output logic [10:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!clk_oe && n < 20) begin @(posedge clk); #1; n++; end
        n = 0;
        while (clk_oe && n < INH + 20) begin @(posedge clk); #1; n++; end
        chk("clk_release", clk_oe, 0);
        if (clk_oe) return;
        bits[0] = ps2_data;
        for (int k = 1; k <= 10; k++) begin
            repeat (half) @(posedge clk); #1;
            dev_clk_low = 1;
            if (k == nfall) begin
                repeat (6) @(posedge clk); #1;
                return;
            end
            repeat (half) @(posedge clk); #1;
            bits[k] = ps2_data;
            dev_clk_low = 0;
        end
        repeat (half) @(posedge clk); #1;
        dev_data_low = ack_ok; dev_clk_low = 1;
        repeat (half) @(posedge clk); #1;
        dev_clk_low = 0;
        repeat (half) @(posedge clk); #1;
        dev_data_low = 0;
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        chk("frame_end", busy, 0);
    endtask

    typedef struct {
        int          op;      // 0 read, 1 write, 2 iack
        logic        a;
        logic [15:0] wd;
        logic [1:0]  s;
        logic [15:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [15:0] q;
        logic [10:0] bits;
        logic [7:0]  b;
        int s_inh, s_st, n, half;
        bit ak, ie_r;

        cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0; iack = 0;
        dev_clk_low = 0; dev_data_low = 0;
        m_reset();

        tbl[0]  = '{0, 1'b0, 16'h0000, 2'b11, 16'h0080, 1'b0};
        tbl[1]  = '{0, 1'b1, 16'h0000, 2'b11, 16'h0000, 1'b0};
        tbl[2]  = '{1, 1'b0, 16'hFFBF, 2'b11, 16'h0000, 1'b0};
        tbl[3]  = '{0, 1'b0, 16'h0000, 2'b11, 16'h0080, 1'b0};
        tbl[4]  = '{1, 1'b0, 16'h0040, 2'b11, 16'h0000, 1'b1};
        tbl[5]  = '{0, 1'b0, 16'h0000, 2'b11, 16'h00C0, 1'b1};
        tbl[6]  = '{2, 1'b0, 16'h0000, 2'b11, 16'h0000, 1'b0};
        tbl[7]  = '{0, 1'b0, 16'h0000, 2'b11, 16'h00C0, 1'b0};
        tbl[8]  = '{1, 1'b0, 16'h0040, 2'b11, 16'h0000, 1'b0};
        tbl[9]  = '{1, 1'b0, 16'h0000, 2'b11, 16'h0000, 1'b0};
        tbl[10] = '{1, 1'b0, 16'h0040, 2'b11, 16'h0000, 1'b1};
        tbl[11] = '{1, 1'b0, 16'h0000, 2'b11, 16'h0000, 1'b0};
        tbl[12] = '{1, 1'b0, 16'h0040, 2'b10, 16'h0000, 1'b0};
        tbl[13] = '{0, 1'b0, 16'h0000, 2'b11, 16'h0080, 1'b0};

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_irq", irq, 0);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        rst = 0;
        @(posedge clk); #1;

        // Register table while idle
        for (int i = 0; i < 14; i++) begin
            case (tbl[i].op)
                0: begin
                    rd(tbl[i].a, q);
                    chk($sformatf("tbl%0d_rd", i), q, tbl[i].exp_rd);
                end
                1: bus(1, tbl[i].a, tbl[i].wd, tbl[i].s, q);
                default: do_iack();
            endcase
            chk($sformatf("tbl%0d_irq", i), irq, tbl[i].exp_irq);
        end

        // LED command with ACK, interrupt enabled
        wr(0, 16'h0040);
        chk("t2_irq_ie_set", irq, 1);
        s_inh = inh_cnt; s_st = st_cnt;
        wr(1, {8'h00, PS2_CMD_LED});
        chk("t2_irq_cleared", irq, 0);
        device_rx(20, 1, 11, bits);
        chk("t2_inhibit_cycles", inh_cnt - s_inh, INH);
        chk("t2_start_cycles", st_cnt - s_st, 1);
        chk("t2_bits", bits, 11'h7DA);
        m_done(1);
        rd(0, q);
        chk("t2_csr", q, 16'h00C0);
        chk("t2_irq", irq, 1);
        do_iack();
        chk("t2_irq_after_iack", irq, 0);

        // Same frame, device withholds ACK
        wr(0, 16'h0000);
        wr(1, {8'h00, PS2_CMD_LED});
        device_rx(17, 0, 11, bits);
        chk("t3_bits", bits, frame_bits(PS2_CMD_LED));
        m_done(0);
        rd(0, q);
        chk("t3_csr", q, 16'o100200);
        chk("t3_irq", irq, 0);

        // Device never clocks: timeout
        wr(1, 16'h0012);
        rd(0, q);
        chk("t4_err_cleared", q, 16'h0000);
        n = 0;
        while (clk_oe && n < INH + 20) begin @(posedge clk); #1; n++; end
        chk("t4_clk_release", clk_oe, 0);
        n = 0;
        while (busy && n < TMO + 20) begin
            @(posedge clk); #1; n++;
            if (n == TMO - 10) begin
                chk("t4_busy_before_expiry", busy, 1);
                chk("t4_start_held", data_oe, 1);
            end
        end
        chk("t4_expired", busy, 0);
        chk("t4_window", (n >= TMO - 4) && (n <= TMO + 4), 1);
        chk("t4_clk_oe", clk_oe, 0);
        chk("t4_data_oe", data_oe, 0);
        m_done(0);
        rd(0, q);
        chk("t4_csr", q, 16'o100200);

        // Write during a frame is ignored
        wr(0, 16'h0040);
        wr(1, {8'h00, PS2_CMD_LED});
        fork
            device_rx(15, 1, 11, bits);
            begin
                logic [15:0] qb;
                repeat (INH + 60) @(posedge clk); #1;
                wr(1, {8'h00, PS2_CMD_RST});
                rd(1, qb);
                chk("t5_buf_unchanged", qb, 16'h00ED);
            end
        join
        chk("t5_bits", bits, frame_bits(PS2_CMD_LED));
        m_done(1);
        rd(0, q);
        chk("t5_csr", q, m_csr());
        chk("t5_irq", irq, m_irq());
        do_iack();

        // Reset during bit 5, then a fresh typematic command
        b = PS2_CMD_LED;
        wr(1, {8'h00, b});
        device_rx(12, 1, 5, bits);
        chk("t6_bit4_driven", data_oe, !b[4]);
        #3 rst = 1;
        #1;
        chk("t6_rst_clk_oe", clk_oe, 0);
        chk("t6_rst_data_oe", data_oe, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_irq", irq, 0);
        @(posedge clk); #1;
        dev_clk_low = 0;
        rst = 0;
        m_reset();
        @(posedge clk); #1;
        rd(0, q);
        chk("t6_csr", q, 16'o000200);
        wr(1, {8'h00, PS2_CMD_TYPEMATIC});
        device_rx(22, 1, 11, bits);
        chk("t6_bits", bits, frame_bits(PS2_CMD_TYPEMATIC));
        m_done(1);
        rd(0, q);
        chk("t6_csr_after", q, m_csr());

        // Randomized frames against the model
        for (int i = 0; i < 6; i++) begin
            b    = 8'($urandom_range(0, 255));
            half = $urandom_range(8, 30);
            ak   = ($urandom_range(0, 3) != 0);
            ie_r = 1'($urandom_range(0, 1));
            wr(0, {9'b0, ie_r, 6'b0});
            chk($sformatf("rnd%0d_irq_pre", i), irq, m_irq());
            s_inh = inh_cnt;
            wr(1, {8'h00, b});
            device_rx(half, ak, 11, bits);
            chk($sformatf("rnd%0d_inhibit", i), inh_cnt - s_inh, INH);
            chk($sformatf("rnd%0d_bits", i), bits, frame_bits(b));
            m_done(ak);
            rd(0, q);
            chk($sformatf("rnd%0d_csr", i), q, m_csr());
            rd(1, q);
            chk($sformatf("rnd%0d_buf", i), q, {8'h00, m_buf});
            chk($sformatf("rnd%0d_irq", i), irq, m_irq());
            if (m_irq()) begin
                do_iack();
                chk($sformatf("rnd%0d_iack", i), irq, m_irq());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
